// File: rtl/jk_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_drv_pkg
// Brief    : Shared request-mode and FSM-state types for the JK bank driver.
// Revision : 1.0 - initial release
// ============================================================================
package jk_drv_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_LOAD   = 2'd1,
    MODE_CLEAR  = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam int c_RETRY_W = 3;

endpackage
`default_nettype wire

// File: rtl/jk_excite.sv
`default_nettype none
// ============================================================================
// Module   : jk_excite
// Brief    : Per-vector JK excitation encoder; exp port exists only when
//            JK_DRIVE_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module jk_excite
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
`ifdef JK_DRIVE_CHECK_EN
  ,
  output logic [WIDTH-1:0] exp
`endif
);

  // LOAD only sets or resets bits that differ, so j=k=1 never appears for it
  always_comb begin
    j = '0;
    k = '0;
    case (mode)
      MODE_LOAD: begin
        j = data & ~q;
        k = ~data & q;
      end
      MODE_CLEAR: begin
        k = '1;
      end
      MODE_TOGGLE: begin
        j = data;
        k = data;
      end
      default: begin
      end
    endcase
  end

`ifdef JK_DRIVE_CHECK_EN
  always_comb begin
    exp = q;
    case (mode)
      MODE_LOAD:   exp = data;
      MODE_CLEAR:  exp = '0;
      MODE_TOGGLE: exp = q ^ data;
      default:     exp = q;
    endcase
  end
`endif

endmodule
`default_nettype wire

// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_driver
// Brief    : Drives j/k of a negedge JK bank toward a requested state, with
//            read-back check and retry when JK_DRIVE_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_j, r_k, w_j_nxt, w_k_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] w_xj, w_xk, w_x_data;
  mode_e            w_x_mode;

`ifdef JK_DRIVE_CHECK_EN
  logic [WIDTH-1:0]     r_exp, w_exp_nxt, w_xexp;
  logic [c_RETRY_W-1:0] r_retry, w_retry_nxt;
  logic                 r_err, w_err_nxt;

  // A retry re-drives as a LOAD toward the stored expectation
  assign w_x_mode = (r_state == ST_CHECK) ? MODE_LOAD : mode_e'(req_mode);
  assign w_x_data = (r_state == ST_CHECK) ? r_exp : req_data;
`else
  assign w_x_mode = mode_e'(req_mode);
  assign w_x_data = req_data;
`endif

  jk_excite #(
    .WIDTH (WIDTH)
  ) u_excite (
    .mode (w_x_mode),
    .data (w_x_data),
    .q    (q_fb),
    .j    (w_xj),
    .k    (w_xk)
`ifdef JK_DRIVE_CHECK_EN
    ,
    .exp  (w_xexp)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_j     <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
`ifdef JK_DRIVE_CHECK_EN
      r_exp   <= '0;
      r_retry <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_done  <= w_done_nxt;
`ifdef JK_DRIVE_CHECK_EN
      r_exp   <= w_exp_nxt;
      r_retry <= w_retry_nxt;
      r_err   <= w_err_nxt;
`endif
    end
  end

  // j/k are loaded on the edge that enters DRIVE so they are stable for the
  // bank's falling-edge sample in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = '0;
    w_k_nxt     = '0;
    w_done_nxt  = 1'b0;
`ifdef JK_DRIVE_CHECK_EN
    w_exp_nxt   = r_exp;
    w_retry_nxt = r_retry;
    w_err_nxt   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt = ST_DRIVE;
          w_j_nxt     = w_xj;
          w_k_nxt     = w_xk;
`ifdef JK_DRIVE_CHECK_EN
          w_exp_nxt   = w_xexp;
          w_retry_nxt = '0;
`endif
        end
      end
      ST_DRIVE: begin
        w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
`ifdef JK_DRIVE_CHECK_EN
        if (q_fb == r_exp) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_retry < c_RETRY_W'(MAX_RETRY)) begin
          w_retry_nxt = r_retry + c_RETRY_W'(1);
          w_state_nxt = ST_DRIVE;
          w_j_nxt     = w_xj;
          w_k_nxt     = w_xk;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`else
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign req_ready = (r_state == ST_IDLE) && !reset;
  assign busy      = (r_state != ST_IDLE);
  assign j         = r_j;
  assign k         = r_k;
  assign done      = r_done;
`ifdef JK_DRIVE_CHECK_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_driver
// Brief    : Directed bench for jk_bank_driver with a negedge JK bank model
//            and an injectable stuck-at-0 fault mask.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bank_driver;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_mode;
  logic [W-1:0] req_data;
  logic [W-1:0] q_fb;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         busy;
  logic         done;
  logic         err;

  logic [W-1:0] bank;
  logic [W-1:0] stuck;
  logic         preload_en;
  logic [W-1:0] preload_val;

  int n_cmp;
  int n_fail;

  jk_bank_driver #(
    .WIDTH     (W),
    .MAX_RETRY (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Negedge JK bank: q+ = j&~q | ~k&q
  always @(negedge clk) begin
    if (preload_en) bank <= preload_val;
    else            bank <= (j & ~bank) | (~k & bank);
  end
  assign q_fb = bank & ~stuck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [W-1:0] v);
    preload_en  = 1'b1;
    preload_val = v;
    @(negedge clk);
    #1;
    preload_en  = 1'b0;
  endtask

  // Presents one request and returns 1ns after the accepting edge A
  task automatic issue(input logic [1:0] m, input logic [W-1:0] d);
    req_valid = 1'b1;
    req_mode  = m;
    req_data  = d;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int drives;
    int d_at;
    int e_at;
    int extra;

    n_cmp       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_mode    = 2'd0;
    req_data    = '0;
    stuck       = '0;
    preload_en  = 1'b0;
    preload_val = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    reset = 1'b0;
    step();
    chk("idle_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_j", j, 0);

    // LOAD 0110 from 0101
    preload(4'b0101);
    chk("pre_load_q", q_fb, 4'b0101);
    issue(2'd1, 4'b0110);
    chk("load_j", j, 4'b0010);
    chk("load_k", k, 4'b0001);
    chk("load_busy", busy, 1);
    chk("load_ready", req_ready, 0);
    step();
    chk("load_chk_j", j, 0);
    chk("load_chk_k", k, 0);
    chk("load_chk_done", done, 0);
    chk("load_q", q_fb, 4'b0110);
    step();
    chk("load_done", done, 1);
    chk("load_err", err, 0);
    chk("load_ready2", req_ready, 1);
    chk("load_busy2", busy, 0);
    step();
    chk("load_done_pulse", done, 0);

    // TOGGLE mask 1001 from 1011
    preload(4'b1011);
    issue(2'd3, 4'b1001);
    chk("tog_j", j, 4'b1001);
    chk("tog_k", k, 4'b1001);
    step();
    step();
    chk("tog_done", done, 1);
    chk("tog_q", q_fb, 4'b0010);

    // CLEAR from 1111
    preload(4'b1111);
    issue(2'd2, 4'b1010);
    chk("clr_j", j, 0);
    chk("clr_k", k, 4'b1111);
    step();
    step();
    chk("clr_done", done, 1);
    chk("clr_q", q_fb, 0);

    // HOLD at 1010
    preload(4'b1010);
    issue(2'd0, 4'b0101);
    chk("hold_j", j, 0);
    chk("hold_k", k, 0);
    step();
    step();
    chk("hold_done", done, 1);
    chk("hold_q", q_fb, 4'b1010);

    // Bit 2 stuck at 0, LOAD 0100
    stuck = 4'b0100;
    preload(4'b0000);
    issue(2'd1, 4'b0100);
    drives = 0;
    d_at   = -1;
    e_at   = -1;
    for (int i = 0; i < 10; i++) begin
      if (j == 4'b0100) drives++;
      if (done && d_at < 0) d_at = i;
      if (err && e_at < 0) e_at = i;
      step();
    end
`ifdef JK_DRIVE_CHECK_EN
    chk("stuck_drives", drives, 4);
    chk("stuck_done_at", d_at, -1);
    chk("stuck_err_at", e_at, 8);
`else
    chk("stuck_drives", drives, 1);
    chk("stuck_done_at", d_at, 2);
    chk("stuck_err_at", e_at, -1);
`endif
    stuck = '0;

    // Reset during DRIVE
    preload(4'b0000);
    issue(2'd1, 4'b1111);
    chk("mid_j", j, 4'b1111);
    reset = 1'b1;
    step();
    chk("mid_rst_j", j, 0);
    chk("mid_rst_k", k, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done || err) extra++;
    end
    chk("mid_no_pulse", extra, 0);
    chk("mid_ready", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jk_bank_driver.md
# jk_bank_driver

Controller that drives the j/k inputs of a WIDTH-bit bank of negedge-clocked JK flip-flops to reach a requested state. It runs on the rising edge, so j/k are stable at the bank's falling-edge sample. It reads the bank's q outputs back, compares them with the expected value, retries on mismatch, and reports done or error. It sits between sequencing logic and the JK register bank, as the excitation side of the flip-flop interface.

## Interface
- WIDTH, 4: number of JK flip-flops driven.
- MAX_RETRY, 3: re-drive attempts after a failed check before reporting an error (range 0..7).

Ports:
- clk  in  1  rising-edge clock. The bank runs on the same clock, falling edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_mode  in  2  0 HOLD, 1 LOAD, 2 CLEAR, 3 TOGGLE.
- req_data  in  WIDTH  LOAD: target value. TOGGLE: toggle mask. Ignored for HOLD and CLEAR.
- q_fb  in  WIDTH  q outputs of the bank.
- j  out  WIDTH  registered J drives.
- k  out  WIDTH  registered K drives.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse on success.
- err  out  1  one-cycle pulse when retries are exhausted.

## Operation
- Reset values: j=0, k=0, done=0, err=0, busy=0, req_ready=0 during reset. State goes to IDLE and retry_cnt to 0. The bank's own reset is not driven by this block.
- Request handshake: a request is accepted on a rising edge where req_valid && req_ready. req_mode and req_data are registered at that edge.
- LOAD excitation, per bit, target t vs current q:
  - t=1, q=0: j=1, k=0.
  - t=0, q=1: j=0, k=1.
  - t=q: j=0, k=0.
  - j=k=1 is never used for LOAD.
- Expected value (exp) per mode, captured from q_fb in the first DRIVE cycle:
  - LOAD: exp = req_data.
  - CLEAR: j=0, k=all-ones, exp = 0.
  - HOLD: j=k=0, exp = q_fb.
  - TOGGLE: j=k=mask, exp = q_fb ^ mask.
- States:
  - IDLE: j=k=0. On accept, go to DRIVE.
  - DRIVE: drive the excitation for one cycle, then go to CHECK.
  - CHECK: j=k=0. Compare q_fb with exp.
    - Match: pulse done, go to IDLE.
    - Mismatch and retry_cnt < MAX_RETRY: retry_cnt++, go to DRIVE.
    - Otherwise: pulse err, go to IDLE.
- Retry DRIVE always uses LOAD excitation toward exp, computed from the current q_fb. A TOGGLE is therefore never re-toggled.
- retry_cnt clears on every accept.
- MAX_RETRY=0: the first mismatch gives err.
- Reset mid-operation: j/k drop to 0 at that edge and the request is discarded with no done or err.

## Timing
- Accept at edge A.
- DRIVE during cycle A..A+1, with j/k valid from edge A. The bank samples at the falling edge inside this cycle.
- CHECK compares q_fb at edge A+2.
- done and err are registered: high during cycle A+2..A+3.
- req_ready is high again from edge A+2, so back-to-back requests can be accepted at A+2.
- Success latency is 2 cycles. Each retry adds 2 cycles. Worst case is 2·(MAX_RETRY+1).
- done and err are never high together.

## Configuration
- JK_DRIVE_CHECK_EN defined: CHECK compares and retries as above.
- JK_DRIVE_CHECK_EN undefined:
  - CHECK is a settle cycle with no comparison, and done always pulses at A+2.
  - err is tied to 0 and retry_cnt is removed.
  - exp is not stored.

## Structure
- Package jk_drv_pkg holds:
  - the mode enum (HOLD, LOAD, CLEAR, TOGGLE);
  - the FSM state enum (IDLE, DRIVE, CHECK);
  - the retry counter width constant (3).
- Sub-module jk_excite: combinational per-vector encoder. Inputs: mode, data, q. Outputs: j, k, exp.
- Top level holds the FSM, request registers, retry counter and j/k output registers.

## Test plan
- Reset held for 2 cycles, then released, with no request → j=k=0, done=err=busy=0, req_ready=1.
- Bank at 4'b0101, LOAD 4'b0110:
  - j=4'b0010, k=4'b0001 for one cycle;
  - q_fb=4'b0110 at CHECK;
  - done at A+2.
- Bank at 4'b1011, TOGGLE mask 4'b1001 → j=k=4'b1001, q_fb=4'b0010, done.
- Bank at 4'b1111, CLEAR → k=4'b1111, j=0, done, q_fb=0.
- Stuck-at-0 bit 2 in the bench, LOAD 4'b0100, MAX_RETRY=3:
  - four DRIVE cycles with j=4'b0100;
  - err pulse at A+8;
  - no done.
  - With JK_DRIVE_CHECK_EN undefined: done at A+2 and no retries.
- reset asserted during DRIVE → j=k=0 on the next edge, no done/err, req_ready=1 after release.
